// File: rtl/arp_pkg.sv
// Shared ARP definitions: FSM states, frame byte indices, protocol constants, CRC32 constants.
// Used by the ARP transmitter and the RX FCS checker.
package arp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_ETH_HDR,
        ST_ARP_HDR,
        ST_ARP_ADDR,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } arp_tx_state_e;

    // Start-time snapshot of the request inputs, held for the whole frame
    typedef struct packed {
        logic        op;
        logic [47:0] mac;
        logic [31:0] ip;
    } arp_tx_req_t;

    localparam int unsigned CNT_W = 8;

    // Last byte index of each frame section
    localparam logic [CNT_W-1:0] PREAMBLE_END = 8'd6;
    localparam logic [CNT_W-1:0] SFD_END      = 8'd7;
    localparam logic [CNT_W-1:0] ETH_HDR_END  = 8'd21;
    localparam logic [CNT_W-1:0] ARP_HDR_END  = 8'd29;
    localparam logic [CNT_W-1:0] ARP_ADDR_END = 8'd49;
    localparam logic [CNT_W-1:0] PAD_END      = 8'd67;
    localparam logic [CNT_W-1:0] FRAME_END    = 8'd71;
    localparam logic [CNT_W-1:0] CRC_FIRST    = 8'd8;
    localparam logic [CNT_W-1:0] IFG_LAST     = 8'd11;

    localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
    localparam logic [15:0] HTYPE_ETH    = 16'h0001;
    localparam logic [15:0] PTYPE_IP     = 16'h0800;
    localparam logic [7:0]  HLEN         = 8'd6;
    localparam logic [7:0]  PLEN         = 8'd4;
    localparam logic [15:0] OP_REQ       = 16'h0001;
    localparam logic [15:0] OP_REP       = 16'h0002;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    localparam logic [31:0] CRC32_POLY      = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_POLY_REFL = reflect32(CRC32_POLY);
    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;

endpackage

// File: rtl/crc32_d8.sv
// Combinational Ethernet CRC32 (reflected) advance by one data byte.
// Shared between the ARP transmitter and the RX FCS checker.
module crc32_d8
    import arp_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc_c
);

    logic [31:0] w_crc;

    // LSB-first bitwise division, one iteration per data bit
    always_comb begin
        w_crc = i_crc ^ {24'h0, i_data};
        for (int b = 0; b < 8; b++) begin
            w_crc = w_crc[0] ? ((w_crc >> 1) ^ CRC32_POLY_REFL) : (w_crc >> 1);
        end
        o_crc_c = w_crc;
    end

endmodule

// File: rtl/arp_tx.sv
// Byte-serial ARP frame transmitter: one 72-byte Ethernet/ARP frame per accepted start.
// Optional inter-frame gap after the FCS is enabled by defining ARP_TX_IFG_EN.
module arp_tx
    import arp_pkg::*;
#(
    parameter logic [47:0] FPGA_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] FPGA_IP  = 32'hc0_a8_00_03
) (
    input  logic        arp_rx_clk,
    input  logic        rstn,
    input  logic        arp_tx_en,
    input  logic        arp_tx_op,
    input  logic [47:0] dst_mac,
    input  logic [31:0] dst_ip,
    output logic [7:0]  arp_tx_data,
    output logic        arp_tx_valid,
    output logic        arp_tx_busy,
    output logic        arp_tx_done
);

    arp_tx_state_e     r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_idx;
    arp_tx_req_t       r_req, w_req_nxt;
    logic [31:0]       r_crc, w_crc_nxt, w_crc_upd, w_fcs;
    logic [7:0]        r_data, w_data_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;

    // CRC advances over the byte currently on the output
    crc32_d8 u_crc (
        .i_crc   (r_crc),
        .i_data  (r_data),
        .o_crc_c (w_crc_upd)
    );

    assign w_idx = r_cnt + CNT_W'(1);
    // Byte 67 is still being folded in when byte 68 is produced
    assign w_fcs = (r_cnt == PAD_END) ? w_crc_upd : r_crc;

    function automatic logic [7:0] frame_byte(
        input logic [CNT_W-1:0] n,
        input arp_tx_req_t      req,
        input logic [31:0]      fcs
    );
        logic [15:0] op16;
        logic [7:0]  b;
        op16 = req.op ? OP_REQ : OP_REP;
        case (n) inside
            [8'd0:PREAMBLE_END]: b = 8'h55;
            SFD_END:             b = 8'hD5;
            [8'd8:8'd13]:        b = req.op ? 8'hFF : 8'(req.mac >> (8 * (13 - n)));
            [8'd14:8'd19]:       b = 8'(FPGA_MAC >> (8 * (19 - n)));
            8'd20:               b = 8'(ETH_TYPE_ARP >> 8);
            8'd21:               b = 8'(ETH_TYPE_ARP);
            8'd22:               b = 8'(HTYPE_ETH >> 8);
            8'd23:               b = 8'(HTYPE_ETH);
            8'd24:               b = 8'(PTYPE_IP >> 8);
            8'd25:               b = 8'(PTYPE_IP);
            8'd26:               b = HLEN;
            8'd27:               b = PLEN;
            8'd28:               b = 8'(op16 >> 8);
            8'd29:               b = 8'(op16);
            [8'd30:8'd35]:       b = 8'(FPGA_MAC >> (8 * (35 - n)));
            [8'd36:8'd39]:       b = 8'(FPGA_IP >> (8 * (39 - n)));
            [8'd40:8'd45]:       b = req.op ? 8'h00 : 8'(req.mac >> (8 * (45 - n)));
            [8'd46:ARP_ADDR_END]: b = 8'(req.ip >> (8 * (49 - n)));
            [8'd68:FRAME_END]:   b = 8'((~fcs) >> (8 * (n - 68)));
            default:             b = 8'h00;
        endcase
        return b;
    endfunction

    always_ff @(posedge arp_rx_clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_req   <= '0;
            r_crc   <= CRC32_INIT;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_req   <= w_req_nxt;
            r_crc   <= w_crc_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_nxt   = r_req;
        w_crc_nxt   = r_crc;
        w_data_nxt  = 8'h00;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                w_crc_nxt = CRC32_INIT;
                if (arp_tx_en) begin
                    w_req_nxt   = '{op: arp_tx_op, mac: dst_mac, ip: dst_ip};
                    w_state_nxt = ST_PREAMBLE;
                    w_data_nxt  = 8'h55;
                    w_valid_nxt = 1'b1;
                end
            end
            ST_IFG: begin
                if (r_cnt == IFG_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_idx;
                end
            end
            default: begin
                if (r_cnt >= CRC_FIRST && r_cnt <= PAD_END) begin
                    w_crc_nxt = w_crc_upd;
                end
                if (r_cnt == FRAME_END) begin
                    w_cnt_nxt = '0;
`ifdef ARP_TX_IFG_EN
                    w_state_nxt = ST_IFG;
`else
                    w_state_nxt = ST_IDLE;
`endif
                end else begin
                    w_cnt_nxt   = w_idx;
                    w_data_nxt  = frame_byte(w_idx, r_req, w_fcs);
                    w_valid_nxt = 1'b1;
                    w_done_nxt  = (w_idx == FRAME_END);
                    case (r_state)
                        ST_PREAMBLE: if (r_cnt == PREAMBLE_END) w_state_nxt = ST_SFD;
                        ST_SFD:      if (r_cnt == SFD_END)      w_state_nxt = ST_ETH_HDR;
                        ST_ETH_HDR:  if (r_cnt == ETH_HDR_END)  w_state_nxt = ST_ARP_HDR;
                        ST_ARP_HDR:  if (r_cnt == ARP_HDR_END)  w_state_nxt = ST_ARP_ADDR;
                        ST_ARP_ADDR: if (r_cnt == ARP_ADDR_END) w_state_nxt = ST_PAD;
                        ST_PAD:      if (r_cnt == PAD_END)      w_state_nxt = ST_FCS;
                        default:     ;
                    endcase
                end
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign arp_tx_data  = r_data;
    assign arp_tx_valid = r_valid;
    assign arp_tx_busy  = r_busy;
    assign arp_tx_done  = r_done;

endmodule

// File: tb/tb_arp_tx.sv
// Scoreboard bench for arp_tx: expected frames are built in software at start time
// and compared byte-by-byte as the transmitter emits them.
`timescale 1ns/1ps
module tb_arp_tx;

    localparam logic [47:0] L_MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] L_IP  = 32'hc0_a8_00_03;
`ifdef ARP_TX_IFG_EN
    localparam bit IFG     = 1'b1;
    localparam int SPACING = 85;
`else
    localparam bit IFG     = 1'b0;
    localparam int SPACING = 73;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        op;
    logic [47:0] mac;
    logic [31:0] ip;
    logic [7:0]  data;
    logic        valid;
    logic        busy;
    logic        done;

    arp_tx #(.FPGA_MAC(L_MAC), .FPGA_IP(L_IP)) dut (
        .arp_rx_clk   (clk),
        .rstn         (rstn),
        .arp_tx_en    (en),
        .arp_tx_op    (op),
        .dst_mac      (mac),
        .dst_ip       (ip),
        .arp_tx_data  (data),
        .arp_tx_valid (valid),
        .arp_tx_busy  (busy),
        .arp_tx_done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       last;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   sd = 1000;
    int   last_rise = -1;
    int   n_rise = 0;
    bit   spc_arm = 1'b0;
    logic prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++) begin
            if (r[0]) r = (r >> 1) ^ 32'hEDB8_8320;
            else      r = r >> 1;
        end
        return r;
    endfunction

    task automatic push_frame(input logic o, input logic [47:0] m, input logic [31:0] a);
        logic [7:0]  f[72];
        logic [31:0] crc;
        exp_t        e;
        for (int i = 0; i < 72; i++) f[i] = 8'h00;
        for (int i = 0; i < 7; i++) f[i] = 8'h55;
        f[7] = 8'hD5;
        for (int k = 0; k < 6; k++) begin
            f[8+k]  = o ? 8'hFF : 8'(m >> (40 - 8*k));
            f[14+k] = 8'(L_MAC >> (40 - 8*k));
            f[30+k] = 8'(L_MAC >> (40 - 8*k));
            f[40+k] = o ? 8'h00 : 8'(m >> (40 - 8*k));
        end
        f[20] = 8'h08; f[21] = 8'h06; f[22] = 8'h00; f[23] = 8'h01;
        f[24] = 8'h08; f[25] = 8'h00; f[26] = 8'h06; f[27] = 8'h04;
        f[28] = 8'h00; f[29] = o ? 8'h01 : 8'h02;
        for (int k = 0; k < 4; k++) begin
            f[36+k] = 8'(L_IP >> (24 - 8*k));
            f[46+k] = 8'(a >> (24 - 8*k));
        end
        crc = 32'hFFFF_FFFF;
        for (int i = 8; i < 68; i++) crc = crc_upd(crc, f[i]);
        crc = ~crc;
        for (int k = 0; k < 4; k++) f[68+k] = 8'(crc >> (8*k));
        for (int i = 0; i < 72; i++) begin
            e.d    = f[i];
            e.last = (i == 71);
            q.push_back(e);
        end
    endtask

    // Output monitor: samples 1 ns after each rising edge
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (valid) begin
            check("busy_in_frame", 32'(busy), 32'd1);
            if (q.size() == 0) begin
                check("unexpected_byte", 32'(data), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                check("data", 32'(data), 32'(e.d));
                check("done", 32'(done), 32'(e.last));
            end
            if (!prev_valid && spc_arm) begin
                if (last_rise >= 0) check("spacing", 32'(cyc - last_rise), 32'(SPACING));
                last_rise = cyc;
                n_rise++;
            end
        end else begin
            check("idle_data", 32'(data), 32'd0);
            check("idle_done", 32'(done), 32'd0);
        end
        sd = done ? 0 : sd + 1;
        if (!spc_arm && rstn) begin
            if (sd == 1)  check("busy_after_done", 32'(busy), 32'(IFG));
            if (sd == 12) check("busy_ifg_end", 32'(busy), 32'(IFG));
            if (sd == 13) check("busy_released", 32'(busy), 32'd0);
        end
        prev_valid = valid;
    end

    task automatic start(input logic o, input logic [47:0] m, input logic [31:0] a);
        check("busy_before_start", 32'(busy), 32'd0);
        op  = o;
        mac = m;
        ip  = a;
        en  = 1'b1;
        push_frame(o, m, a);
        @(negedge clk);
        en = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle(input int max_cyc);
        int k;
        k = 0;
        while ((q.size() != 0 || busy) && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        check("drain_in_time", 32'(k < max_cyc), 32'd1);
        repeat (16) @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0;
        en   = 1'b0;
        op   = 1'b0;
        mac  = '0;
        ip   = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_data",  32'(data),  32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Request and reply frames
        start(1'b1, 48'h0, 32'hc0a8_0002);
        wait_idle(300);
        start(1'b0, 48'ha0b1_c2d3_e4f5, 32'hc0a8_0002);
        wait_idle(300);

        // Inputs changed while the frame is in flight must not leak into it
        start(1'b0, 48'h0123_4567_89ab, 32'h0a00_0001);
        repeat (35) @(negedge clk);
        mac = ~mac;
        op  = 1'b1;
        ip  = 32'hdead_beef;
        en  = 1'b1;
        @(negedge clk);
        en  = 1'b0;
        wait_idle(300);

        // Reset while byte 30 is on the output abandons the frame
        start(1'b1, 48'h0, 32'hc0a8_00fe);
        repeat (30) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_busy",  32'(busy),  32'd0);
        check("midrst_done",  32'(done),  32'd0);
        q.delete();
        rstn = 1'b1;
        @(negedge clk);
        start(1'b0, 48'h5a5a_a5a5_0f0f, 32'hc0a8_0010);
        wait_idle(300);

        // Start held high: back-to-back frames at minimum spacing
        op  = 1'b1;
        mac = 48'h0;
        ip  = 32'hc0a8_0063;
        for (int i = 0; i < 3; i++) push_frame(1'b1, 48'h0, 32'hc0a8_0063);
        spc_arm   = 1'b1;
        last_rise = -1;
        n_rise    = 0;
        en = 1'b1;
        repeat (200) @(negedge clk);
        en = 1'b0;
        wait_idle(400);
        spc_arm = 1'b0;
        check("b2b_frames", 32'(n_rise), 32'd3);
        check("final_valid", 32'(valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
